// File: rtl/jk_bank_access_ctrl_if.sv
// Requester, bank and response signals of the shared JK bank controller.
// The controller connects through the slave modport.
interface jk_bank_access_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             req0_valid;
  logic [1:0]       req0_op;
  logic [WIDTH-1:0] req0_data;
  logic             req0_ready;
  logic             req1_valid;
  logic [1:0]       req1_op;
  logic [WIDTH-1:0] req1_data;
  logic             req1_ready;
  logic [WIDTH-1:0] j_vec;
  logic [WIDTH-1:0] k_vec;
  logic             jk_en;
  logic [WIDTH-1:0] bank_q;
  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic             rsp_ok;
  logic [WIDTH-1:0] rsp_q;
  logic             busy;

  modport slave (
    input  req0_valid, req0_op, req0_data,
    input  req1_valid, req1_op, req1_data,
    input  bank_q, rsp_ready,
    output req0_ready, req1_ready,
    output j_vec, k_vec, jk_en,
    output rsp_valid, rsp_id, rsp_ok, rsp_q, busy
  );

  modport master (
    output req0_valid, req0_op, req0_data,
    output req1_valid, req1_op, req1_data,
    output bank_q, rsp_ready,
    input  req0_ready, req1_ready,
    input  j_vec, k_vec, jk_en,
    input  rsp_valid, rsp_id, rsp_ok, rsp_q, busy
  );
endinterface

// File: rtl/jk_bank_access_ctrl.sv
// Round-robin controller sharing one JK flip-flop bank between two requesters:
// translates commands to J/K excitation, pulses the bank once and verifies the readback.
module jk_bank_access_ctrl #(
  parameter int WIDTH = 8
) (
  input logic                   clk,
  input logic                   reset,
  jk_bank_access_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    CHECK = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [1:0] OP_LOAD   = 2'b00;
  localparam logic [1:0] OP_TOGGLE = 2'b01;
  localparam logic [1:0] OP_SET    = 2'b10;
  localparam logic [1:0] OP_CLEAR  = 2'b11;

  state_t           r_state;
  state_t           w_nextState;

  logic [1:0]       r_op;
  logic [WIDTH-1:0] r_data;
  logic             r_id;
  logic             r_lastGrant;
  logic [WIDTH-1:0] r_expected;
  logic [WIDTH-1:0] r_jVec;
  logic [WIDTH-1:0] r_kVec;
  logic             r_jkEn;
  logic             r_rspValid;
  logic             r_rspId;
  logic             r_rspOk;
  logic [WIDTH-1:0] r_rspQ;

  logic             w_grant0;
  logic             w_grant1;
  logic             w_accept;
  logic [1:0]       w_selOp;
  logic [WIDTH-1:0] w_selData;
  logic [WIDTH-1:0] w_jNext;
  logic [WIDTH-1:0] w_kNext;
  logic [WIDTH-1:0] w_expectedNext;

  // On a conflict the requester that did not win last time is served.
  assign w_grant0  = bus.req0_valid & (~bus.req1_valid | r_lastGrant);
  assign w_grant1  = bus.req1_valid & (~bus.req0_valid | ~r_lastGrant);
  assign w_accept  = (r_state == IDLE) & (bus.req0_valid | bus.req1_valid);
  assign w_selOp   = w_grant1 ? bus.req1_op   : bus.req0_op;
  assign w_selData = w_grant1 ? bus.req1_data : bus.req0_data;

  always_comb begin
    w_jNext = '0;
    w_kNext = '0;
    case (w_selOp)
      OP_LOAD: begin
        w_jNext = w_selData;
        w_kNext = ~w_selData;
      end
      OP_TOGGLE: begin
        w_jNext = w_selData;
        w_kNext = w_selData;
      end
      OP_SET: begin
        w_jNext = w_selData;
      end
      default: begin
        w_kNext = w_selData;
      end
    endcase
  end

  // Expected bank value after the pulse, from the pre-update bank sampled in APPLY.
  always_comb begin
    w_expectedNext = bus.bank_q;
    case (r_op)
      OP_LOAD:   w_expectedNext = r_data;
      OP_TOGGLE: w_expectedNext = bus.bank_q ^ r_data;
      OP_SET:    w_expectedNext = bus.bank_q | r_data;
      default:   w_expectedNext = bus.bank_q & ~r_data;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_nextState = APPLY;
      APPLY:   w_nextState = CHECK;
      CHECK:   w_nextState = RESP;
      RESP:    if (bus.rsp_ready) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_op        <= OP_LOAD;
      r_data      <= '0;
      r_id        <= 1'b0;
      r_lastGrant <= 1'b1;
      r_expected  <= '0;
      r_jVec      <= '0;
      r_kVec      <= '0;
      r_jkEn      <= 1'b0;
      r_rspValid  <= 1'b0;
      r_rspId     <= 1'b0;
      r_rspOk     <= 1'b0;
      r_rspQ      <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_op        <= w_selOp;
            r_data      <= w_selData;
            r_id        <= w_grant1;
            r_lastGrant <= w_grant1;
            r_jVec      <= w_jNext;
            r_kVec      <= w_kNext;
            r_jkEn      <= 1'b1;
          end
        end
        APPLY: begin
          r_jVec     <= '0;
          r_kVec     <= '0;
          r_jkEn     <= 1'b0;
          r_expected <= w_expectedNext;
        end
        CHECK: begin
          r_rspQ     <= bus.bank_q;
          r_rspOk    <= (bus.bank_q == r_expected);
          r_rspId    <= r_id;
          r_rspValid <= 1'b1;
        end
        default: begin
          if (bus.rsp_ready) r_rspValid <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    bus.req0_ready = (r_state == IDLE) & w_grant0;
    bus.req1_ready = (r_state == IDLE) & w_grant1;
    bus.busy       = (r_state != IDLE);
    bus.j_vec      = r_jVec;
    bus.k_vec      = r_kVec;
    bus.jk_en      = r_jkEn;
    bus.rsp_valid  = r_rspValid;
    bus.rsp_id     = r_rspId;
    bus.rsp_ok     = r_rspOk;
    bus.rsp_q      = r_rspQ;
  end

endmodule

// File: tb/tb_jk_bank_access_ctrl.sv
// Directed bench for jk_bank_access_ctrl with a behavioural JK bank
// that can be told to ignore the enable on selected bits.
module tb_jk_bank_access_ctrl;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [WIDTH-1:0] bankQ = '0;
  logic [WIDTH-1:0] ignoreMask = '0;
  int               compareCount = 0;
  int               mismatchCount = 0;

  jk_bank_access_ctrl_if #(.WIDTH(WIDTH)) bus ();

  jk_bank_access_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  assign bus.bank_q = bankQ;

  // Per-bit JK flip-flop: 10 set, 01 clear, 11 toggle, 00 hold.
  always @(posedge clk) begin
    if (bus.jk_en) begin
      for (int b = 0; b < WIDTH; b++) begin
        if (!ignoreMask[b]) begin
          case ({bus.j_vec[b], bus.k_vec[b]})
            2'b10:   bankQ[b] <= 1'b1;
            2'b01:   bankQ[b] <= 1'b0;
            2'b11:   bankQ[b] <= ~bankQ[b];
            default: bankQ[b] <= bankQ[b];
          endcase
        end
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compareCount++;
    if (obs !== exp) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic v0, input logic [1:0] op0, input logic [7:0] d0,
                               input logic v1, input logic [1:0] op1, input logic [7:0] d1);
    bus.req0_valid = v0;
    bus.req0_op    = op0;
    bus.req0_data  = d0;
    bus.req1_valid = v1;
    bus.req1_op    = op1;
    bus.req1_data  = d1;
  endtask

  // Single command from one requester, checked cycle by cycle from T to T+4.
  task automatic runCmd(input logic id, input logic [1:0] op, input logic [7:0] data,
                        input logic [7:0] expJ, input logic [7:0] expK,
                        input logic [7:0] expQ, input logic expOk);
    @(negedge clk);
    applyStimulus(!id, op, data, id, op, data);
    #1;
    checkOutput("ready_granted", id ? bus.req1_ready : bus.req0_ready, 1);
    checkOutput("ready_other", id ? bus.req0_ready : bus.req1_ready, 0);
    @(negedge clk);
    applyStimulus(0, 2'b00, 8'h00, 0, 2'b00, 8'h00);
    checkOutput("apply_jk_en", bus.jk_en, 1);
    checkOutput("apply_j_vec", bus.j_vec, expJ);
    checkOutput("apply_k_vec", bus.k_vec, expK);
    checkOutput("apply_busy", bus.busy, 1);
    @(negedge clk);
    checkOutput("check_jk_en", bus.jk_en, 0);
    checkOutput("check_j_vec", bus.j_vec, 0);
    checkOutput("check_rsp_valid", bus.rsp_valid, 0);
    @(negedge clk);
    checkOutput("resp_valid", bus.rsp_valid, 1);
    checkOutput("resp_id", bus.rsp_id, id);
    checkOutput("resp_q", bus.rsp_q, expQ);
    checkOutput("resp_ok", bus.rsp_ok, expOk);
    @(negedge clk);
    checkOutput("after_rsp_valid", bus.rsp_valid, 0);
    checkOutput("after_busy", bus.busy, 0);
  endtask

  initial begin
    logic [7:0] d0;
    logic [7:0] d1;
    logic       expId;

    applyStimulus(0, 2'b00, 8'h00, 0, 2'b00, 8'h00);
    bus.rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    checkOutput("reset_busy", bus.busy, 0);
    checkOutput("reset_jk_en", bus.jk_en, 0);
    checkOutput("reset_j_vec", bus.j_vec, 0);
    checkOutput("reset_k_vec", bus.k_vec, 0);
    checkOutput("reset_rsp_valid", bus.rsp_valid, 0);
    checkOutput("reset_rsp_q", bus.rsp_q, 0);

    runCmd(0, 2'b00, 8'hA5, 8'hA5, 8'h5A, 8'hA5, 1);
    runCmd(1, 2'b01, 8'h0F, 8'h0F, 8'h0F, 8'hAA, 1);
    runCmd(1, 2'b10, 8'h01, 8'h01, 8'h00, 8'hAB, 1);
    runCmd(1, 2'b11, 8'h80, 8'h00, 8'h80, 8'h2B, 1);
    runCmd(0, 2'b10, 8'h00, 8'h00, 8'h00, 8'h2B, 1);

    // Conflicts right after reset: requester 0 first, then strict alternation.
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    d0 = 8'h11;
    d1 = 8'h22;
    applyStimulus(1, 2'b00, d0, 1, 2'b00, d1);
    for (int n = 0; n < 4; n++) begin
      expId = n[0];
      #1;
      checkOutput("conflict_ready0", bus.req0_ready, !expId);
      checkOutput("conflict_ready1", bus.req1_ready, expId);
      repeat (3) @(negedge clk);
      checkOutput("conflict_rsp_id", bus.rsp_id, expId);
      checkOutput("conflict_rsp_q", bus.rsp_q, expId ? d1 : d0);
      @(negedge clk);
    end
    applyStimulus(0, 2'b00, 8'h00, 0, 2'b00, 8'h00);

    runCmd(0, 2'b00, 8'h00, 8'h00, 8'hFF, 8'h00, 1);
    ignoreMask = 8'h01;
    runCmd(0, 2'b00, 8'hFF, 8'hFF, 8'h00, 8'hFE, 0);
    ignoreMask = 8'h00;

    // Back-pressure: response held, other requester waiting sees no grant.
    bus.rsp_ready = 1'b0;
    @(negedge clk);
    applyStimulus(0, 2'b00, 8'h00, 1, 2'b00, 8'h55);
    #1;
    checkOutput("bp_accept", bus.req1_ready, 1);
    @(negedge clk);
    applyStimulus(1, 2'b00, 8'h77, 0, 2'b00, 8'h00);
    repeat (2) @(negedge clk);
    for (int n = 0; n < 5; n++) begin
      checkOutput("bp_rsp_valid", bus.rsp_valid, 1);
      checkOutput("bp_rsp_id", bus.rsp_id, 1);
      checkOutput("bp_rsp_q", bus.rsp_q, 8'h55);
      checkOutput("bp_rsp_ok", bus.rsp_ok, 1);
      checkOutput("bp_req0_ready", bus.req0_ready, 0);
      checkOutput("bp_jk_en", bus.jk_en, 0);
      if (n < 4) @(negedge clk);
    end
    applyStimulus(0, 2'b00, 8'h00, 0, 2'b00, 8'h00);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    checkOutput("bp_release_valid", bus.rsp_valid, 0);
    checkOutput("bp_release_busy", bus.busy, 0);

    // Reset asserted while the controller is in CHECK abandons the command.
    @(negedge clk);
    applyStimulus(1, 2'b00, 8'h99, 0, 2'b00, 8'h00);
    @(negedge clk);
    applyStimulus(0, 2'b00, 8'h00, 0, 2'b00, 8'h00);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("rst_check_busy", bus.busy, 0);
    checkOutput("rst_check_rsp_valid", bus.rsp_valid, 0);
    checkOutput("rst_check_jk_en", bus.jk_en, 0);
    @(negedge clk);
    checkOutput("rst_check_no_rsp", bus.rsp_valid, 0);
    checkOutput("rst_check_no_pulse", bus.jk_en, 0);
    runCmd(0, 2'b00, 8'h3C, 8'h3C, 8'hC3, 8'h3C, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
